// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int BAUD_DIV_DEF = 2604;
  localparam int BAUD_CNT_W   = 12;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side and serial-side signals of the UART receiver.
interface uart_rx_if;

  logic       RX;
  logic       clr_rdy;
  logic       rdy;
  logic [7:0] rx_data;
  logic       frm_err;
  logic       ovr;

  modport master (output RX, clr_rdy, input rdy, rx_data, frm_err, ovr);
  modport slave  (input RX, clr_rdy, output rdy, rx_data, frm_err, ovr);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop RX synchronizer, mid-bit sampling FSM and a
// rdy/clr_rdy byte handshake with sticky framing-error and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  bus
);

  // Reload values are one less than the wanted interval because the sample
  // happens in the cycle the counter sits at zero.
  localparam logic [BAUD_CNT_W-1:0] HALF_LD = BAUD_CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BAUD_CNT_W-1:0] FULL_LD = BAUD_CNT_W'(BAUD_DIV - 1);

  rx_state_t               state_q;
  logic                    rx_s1_q;
  logic                    rx_s2_q;
  logic                    rx_prev_q;
  logic [BAUD_CNT_W-1:0]   baud_cnt_q;
  logic [2:0]              bit_cnt_q;
  logic [7:0]              shift_q;
  logic                    rdy_q;
  logic [7:0]              data_q;
  logic                    frm_q;
  logic                    ovr_q;

  logic baud_zero;
  logic rx_fall;

  assign baud_zero = (baud_cnt_q == '0);
  assign rx_fall   = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      frm_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q   <= bus.RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;

      if (!baud_zero) baud_cnt_q <= baud_cnt_q - 1'b1;

      // Later assignments below take priority, so a good stop bit beats clr_rdy.
      if (bus.clr_rdy) begin
        rdy_q <= 1'b0;
        frm_q <= 1'b0;
        ovr_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rx_fall) begin
            baud_cnt_q <= HALF_LD;
            state_q    <= START;
          end
        end
        START: begin
          if (baud_zero) begin
            if (rx_s2_q) begin
              state_q <= IDLE;
            end else begin
              baud_cnt_q <= FULL_LD;
              bit_cnt_q  <= '0;
              state_q    <= DATA;
            end
          end
        end
        DATA: begin
          if (baud_zero) begin
            shift_q    <= {rx_s2_q, shift_q[7:1]};
            baud_cnt_q <= FULL_LD;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (baud_zero) begin
            if (rx_s2_q) begin
              data_q  <= shift_q;
              rdy_q   <= 1'b1;
              frm_q   <= 1'b0;
              if (rdy_q && !bus.clr_rdy) ovr_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              frm_q   <= 1'b1;
              state_q <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s2_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdy     = rdy_q;
  assign bus.rx_data = data_q;
  assign bus.frm_err = frm_q;
  assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames bit by bit and checks the
// byte handshake, sticky flags, glitch rejection, break recovery and reset.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int B = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic       rdy_pre, rdy_at, frm_at, ovr_at;
  logic [7:0] data_at;

  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    tick();
    bus.clr_rdy = 1'b0;
  endtask

  // clr_mode: 0 none, 1 pulse after the set, 2 pulse in the very cycle of the set.
  // The start edge is driven just after edge 0; the stop-bit sample lands on
  // edge 3 + B/2 + 9*B = 155, so rdy is first seen high at 155+1.
  task automatic send_frame(input logic [7:0] b, input int clr_mode,
                            input logic stop_val, input int stop_len);
    int used;
    bus.RX = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (B) tick();
    end
    bus.RX = stop_val;
    repeat (10) tick();
    rdy_pre = bus.rdy;
    used = 11;
    if (clr_mode == 2) pulse_clr();
    else tick();
    rdy_at  = bus.rdy;
    data_at = bus.rx_data;
    frm_at  = bus.frm_err;
    ovr_at  = bus.ovr;
    if (clr_mode == 1) begin
      pulse_clr();
      used = 12;
    end
    repeat (stop_len - used) tick();
    bus.RX = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_rdy",  32'(bus.rdy), 32'h0);
    chk("rst_data", 32'(bus.rx_data), 32'h00);
    chk("rst_frm",  32'(bus.frm_err), 32'h0);
    chk("rst_ovr",  32'(bus.ovr), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    repeat (5) tick();

    // Single byte with exact rdy timing
    send_frame(8'hA5, 1, 1'b1, B);
    chk("t1_rdy_early", 32'(rdy_pre), 32'h0);
    chk("t1_rdy",       32'(rdy_at), 32'h1);
    chk("t1_data",      32'(data_at), 32'hA5);
    chk("t1_frm",       32'(frm_at), 32'h0);
    chk("t1_rdy_clr",   32'(bus.rdy), 32'h0);

    // Back-to-back frames, consumer keeps up
    send_frame(8'h00, 1, 1'b1, B);
    chk("t2a_rdy",  32'(rdy_at), 32'h1);
    chk("t2a_data", 32'(data_at), 32'h00);
    chk("t2a_ovr",  32'(ovr_at), 32'h0);
    send_frame(8'hFF, 1, 1'b1, B);
    chk("t2b_rdy_early", 32'(rdy_pre), 32'h0);
    chk("t2b_rdy",  32'(rdy_at), 32'h1);
    chk("t2b_data", 32'(data_at), 32'hFF);
    chk("t2b_ovr",  32'(ovr_at), 32'h0);

    // Overrun, then clear; then set coinciding with clr_rdy
    send_frame(8'h11, 0, 1'b1, B);
    chk("t3a_ovr",  32'(ovr_at), 32'h0);
    send_frame(8'h22, 0, 1'b1, B);
    chk("t3b_rdy",  32'(rdy_at), 32'h1);
    chk("t3b_data", 32'(data_at), 32'h22);
    chk("t3b_ovr",  32'(ovr_at), 32'h1);
    pulse_clr();
    chk("t3c_rdy", 32'(bus.rdy), 32'h0);
    chk("t3c_ovr", 32'(bus.ovr), 32'h0);
    send_frame(8'h33, 0, 1'b1, B);
    send_frame(8'h77, 2, 1'b1, B);
    chk("t3d_rdy",  32'(rdy_at), 32'h1);
    chk("t3d_data", 32'(data_at), 32'h77);
    chk("t3d_ovr",  32'(ovr_at), 32'h0);
    pulse_clr();
    chk("t3e_rdy", 32'(bus.rdy), 32'h0);
    repeat (B) tick();

    // Short low glitch is a false start
    bus.RX = 1'b0;
    repeat (5) tick();
    bus.RX = 1'b1;
    repeat (20) tick();
    chk("t4_state", 32'(dut.state_q), 32'(IDLE));
    chk("t4_rdy",   32'(bus.rdy), 32'h0);
    chk("t4_frm",   32'(bus.frm_err), 32'h0);

    // Framing error with a held-low stop, then recovery
    send_frame(8'h3C, 0, 1'b0, 3 * B);
    chk("t5a_frm", 32'(frm_at), 32'h1);
    chk("t5a_rdy", 32'(rdy_at), 32'h0);
    chk("t5a_state", 32'(dut.state_q), 32'(BREAK));
    repeat (B) tick();
    chk("t5b_state", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'h3C, 0, 1'b1, B);
    chk("t5c_rdy",  32'(rdy_at), 32'h1);
    chk("t5c_frm",  32'(frm_at), 32'h0);
    chk("t5c_data", 32'(data_at), 32'h3C);

    // Reset in the middle of the data bits
    bus.RX = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 4; i++) begin
      bus.RX = ~i[0];
      repeat (B) tick();
    end
    rst_n  = 1'b0;
    bus.RX = 1'b1;
    #1;
    chk("t6_rst_rdy",   32'(bus.rdy), 32'h0);
    chk("t6_rst_data",  32'(bus.rx_data), 32'h00);
    chk("t6_rst_frm",   32'(bus.frm_err), 32'h0);
    chk("t6_rst_ovr",   32'(bus.ovr), 32'h0);
    chk("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (B) tick();
    chk("t6_idle_rdy", 32'(bus.rdy), 32'h0);
    send_frame(8'h5A, 1, 1'b1, B);
    chk("t6_rdy_early", 32'(rdy_pre), 32'h0);
    chk("t6_rdy",  32'(rdy_at), 32'h1);
    chk("t6_data", 32'(data_at), 32'h5A);
    chk("t6_ovr",  32'(ovr_at), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
